// File: rtl/r4_stage_ctrl_if.sv
// Scheduler-side handshake and sample RAM / butterfly address bus of the radix-4 stage controller.
// master = stage scheduler / bench, slave = r4_stage_ctrl.
`timescale 1ns/1ps
interface r4_stage_ctrl_if #(
    parameter int ADDR_W = 6
) ();
    logic                  start;
    logic [1:0]            stage;
    logic                  hold;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  rd_en;
    logic [4*ADDR_W-1:0]   rd_addr;
    logic                  wr_en;
    logic [4*ADDR_W-1:0]   wr_addr;
    logic [31:0]           perf_cyc;
    logic [31:0]           perf_hold;

    modport master (
        output start, stage, hold,
        input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, perf_cyc, perf_hold
    );

    modport slave (
        input  start, stage, hold,
        output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, perf_cyc, perf_hold
    );
endinterface

// File: rtl/r4_stage_ctrl.sv
// In-place radix-4 DIF stage sequencer: issues 4 read addresses per group, replays them as writes
// RD_LAT+BF_LAT cycles later. Define R4_CTRL_PERF_EN to build the busy/hold performance counters.
`timescale 1ns/1ps
module r4_stage_ctrl #(
    parameter int N_LOG4 = 3,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 14
) (
    input  logic             clk,
    input  logic             reset,
    r4_stage_ctrl_if.slave   bus
);
    localparam int GW  = 2*N_LOG4 - 2;
    localparam int D   = RD_LAT + BF_LAT;
    localparam int AW4 = 4*ADDR_W;
    localparam logic [ADDR_W-1:0] ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [GW-1:0]             g_q, g_d;
    logic [1:0]                stage_q, stage_d;
    logic                      err_q, err_d;
    logic [D-1:0]              vld_q, vld_d;
    logic [D-1:0][AW4-1:0]     addr_q, addr_d;

    logic                      start_ok, start_bad, issue, last_grp;
    logic [7:0]                sh_l;
    logic [ADDR_W-1:0]         lo_mask, g_ext, a_lo, a_hi;
    logic [AW4-1:0]            grp_addr, rd_addr_w;

    always_comb begin
        start_ok  = (state_q == S_IDLE) && bus.start && (int'(bus.stage) < N_LOG4);
        start_bad = (state_q == S_IDLE) && bus.start && (int'(bus.stage) >= N_LOG4);
        issue     = (state_q == S_ISSUE) && !bus.hold;
        last_grp  = issue && (g_q == '1);
    end

    // Butterfly span is 4**(N_LOG4-1-stage): splice k into the group index at bit L.
    always_comb begin
        sh_l     = 8'(2*(N_LOG4-1)) - {5'b0, stage_q, 1'b0};
        lo_mask  = ~(ONES << sh_l);
        g_ext    = ADDR_W'(g_q);
        a_lo     = g_ext & lo_mask;
        a_hi     = (g_ext & ~lo_mask) << 2;
        grp_addr = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_addr[k*ADDR_W +: ADDR_W] = a_hi | (ADDR_W'(k) << sh_l) | a_lo;
        end
        rd_addr_w = issue ? grp_addr : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_ISSUE;
            S_ISSUE: if (last_grp) state_d = S_DRAIN;
            // Leave once nothing is left behind the output slot; that slot's write is this cycle.
            S_DRAIN: if (vld_q[D-2:0] == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.err     = err_q;
        bus.rd_en   = issue;
        bus.rd_addr = rd_addr_w;
        bus.wr_en   = vld_q[D-1];
        bus.wr_addr = addr_q[D-1];
    end

    always_comb begin
        g_d     = g_q;
        stage_d = stage_q;
        err_d   = start_bad;
        if (start_ok) begin
            g_d     = '0;
            stage_d = bus.stage;
        end else if (issue) begin
            g_d = g_q + GW'(1);
        end
        vld_d  = {vld_q[D-2:0], issue};
        addr_d = {addr_q[D-2:0], rd_addr_w};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q     <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            addr_q  <= '0;
        end else begin
            g_q     <= g_d;
            stage_q <= stage_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
        end
    end

`ifdef R4_CTRL_PERF_EN
    logic [31:0] pcyc_q, pcyc_d, phold_q, phold_d;

    always_comb begin
        pcyc_d  = pcyc_q;
        phold_d = phold_q;
        if (start_ok) begin
            pcyc_d  = '0;
            phold_d = '0;
        end else begin
            if ((state_q != S_IDLE) && (pcyc_q != '1)) pcyc_d = pcyc_q + 32'd1;
            if ((state_q == S_ISSUE) && bus.hold && (phold_q != '1)) phold_d = phold_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcyc_q  <= '0;
            phold_q <= '0;
        end else begin
            pcyc_q  <= pcyc_d;
            phold_q <= phold_d;
        end
    end

    assign bus.perf_cyc  = pcyc_q;
    assign bus.perf_hold = phold_q;
`else
    assign bus.perf_cyc  = '0;
    assign bus.perf_hold = '0;
`endif
endmodule

// File: tb/tb_r4_stage_ctrl.sv
// Randomised bench for r4_stage_ctrl: a cycle-indexed reference model predicts every strobe and address.
`timescale 1ns/1ps
module tb_r4_stage_ctrl;
    localparam int N_LOG4 = 3;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 1;
    localparam int BF_LAT = 14;
    localparam int D      = RD_LAT + BF_LAT;
    localparam int NG     = (4**N_LOG4)/4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    r4_stage_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    r4_stage_ctrl #(
        .N_LOG4(N_LOG4),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .BF_LAT(BF_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Group g of a stage: butterfly legs are 'span' apart inside blocks of 4*span samples.
    function automatic logic [4*ADDR_W-1:0] ref_addr(input int st, input int g);
        int span;
        logic [4*ADDR_W-1:0] r;
        span = 4**(N_LOG4-1-st);
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k*ADDR_W +: ADDR_W] = ADDR_W'((g/span)*span*4 + k*span + g%span);
        return r;
    endfunction

    // mode: 0 no hold, 1 random hold, 2 hold for the three cycles after group 5.
    task automatic run_stage(input int st, input int mode, input int abort_at, input int exp_done_abs);
        bit                  exp_wv[256];
        logic [4*ADDR_W-1:0] exp_wa[256];
        int issued, holds, done_cyc, obs_done;
        bit h, exp_rd, finished;
        for (int i = 0; i < 256; i++) begin
            exp_wv[i] = 1'b0;
            exp_wa[i] = '0;
        end
        issued = 0; holds = 0; done_cyc = -1; obs_done = -1; finished = 1'b0;
        bus.start = 1'b1;
        bus.stage = 2'(st);
        bus.hold  = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (mode == 2)      h = (c >= 7 && c <= 9);
            else if (mode == 1) h = ($urandom_range(0, 3) == 0) && (holds < 20);
            else                h = 1'b0;
            bus.hold = h;
            if (issued < NG && h) holds++;
            if (done_cyc < 0 || c <= done_cyc) begin
                bus.start = ($urandom_range(0, 7) == 0);
                bus.stage = 2'($urandom_range(0, 3));
            end else begin
                bus.start = 1'b0;
            end
            #1;
            exp_rd = (issued < NG) && !h;
            check("rd_en", bus.rd_en, exp_rd);
            if (exp_rd) begin
                check("rd_addr", bus.rd_addr, ref_addr(st, issued));
                exp_wv[c+D] = 1'b1;
                exp_wa[c+D] = ref_addr(st, issued);
                issued++;
                if (issued == NG) done_cyc = c + D + 1;
            end
            check("wr_en", bus.wr_en, exp_wv[c]);
            if (exp_wv[c]) check("wr_addr", bus.wr_addr, exp_wa[c]);
            check("busy", bus.busy, (done_cyc < 0 || c <= done_cyc));
            check("done", bus.done, (c == done_cyc));
            check("err", bus.err, 1'b0);
            if (bus.done && obs_done < 0) obs_done = c;
`ifdef R4_CTRL_PERF_EN
            if (c == 1) begin
                check("perf_cyc_clr", bus.perf_cyc, 0);
                check("perf_hold_clr", bus.perf_hold, 0);
            end
`endif
            if (c == abort_at) begin
                bus.start = 1'b0;
                bus.hold  = 1'b0;
                reset = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_err", bus.err, 0);
                check("rst_rd_en", bus.rd_en, 0);
                check("rst_rd_addr", bus.rd_addr, 0);
                check("rst_wr_en", bus.wr_en, 0);
                check("rst_wr_addr", bus.wr_addr, 0);
                for (int j = 0; j < 25; j++) begin
                    @(posedge clk);
                    #1 reset = 1'b1;
                    check("abort_wr_en", bus.wr_en, 0);
                    check("abort_done", bus.done, 0);
                    check("abort_busy", bus.busy, 0);
                end
                return;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        check("stage_finished", finished, 1'b1);
        check("done_cycle", obs_done, done_cyc);
        if (exp_done_abs > 0) check("done_cycle_abs", obs_done, exp_done_abs);
`ifdef R4_CTRL_PERF_EN
        check("perf_cyc", bus.perf_cyc, done_cyc);
        check("perf_hold", bus.perf_hold, holds);
`else
        check("perf_cyc_tied", bus.perf_cyc, 0);
        check("perf_hold_tied", bus.perf_hold, 0);
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stage = '0;
        bus.hold  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_stage(0, 0, 0, 32);
        run_stage(1, 0, 0, 32);
        run_stage(2, 0, 0, 32);
        run_stage(0, 2, 0, 35);

        bus.start = 1'b1;
        bus.stage = 2'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("err_pulse", bus.err, 1);
        check("err_busy", bus.busy, 0);
        check("err_rd_en", bus.rd_en, 0);
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            check("err_clear", bus.err, 0);
            check("err_idle_busy", bus.busy, 0);
            check("err_idle_rd_en", bus.rd_en, 0);
            check("err_idle_wr_en", bus.wr_en, 0);
        end

        run_stage(0, 0, 10, -1);
        run_stage(0, 0, 0, 32);
        for (int r = 0; r < 6; r++) run_stage(int'($urandom_range(0, 2)), 1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
